// File: rtl/cpu_multiciclo.sv
// Three-state (fetch/decode/execute) accumulator-pair CPU with asynchronous-read instruction memory.
// Optional macro CPU_HALT_EN: opcode F parks the CPU in HALT until reset.
module cpu_multiciclo #(
   parameter int PC_W     = 12,
   parameter int DATA_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   output logic [PC_W-1:0]   contador,
   output logic [3:0]        opcode,
   output logic              equal,
   output logic [DATA_W-1:0] regA,
   output logic [DATA_W-1:0] regB,
   output logic              halted
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DECODE  = 2'd1,
      EXECUTE = 2'd2
`ifdef CPU_HALT_EN
      , HALT  = 2'd3
`endif
   } state_t;

   localparam logic [3:0] OP_LDA   = 4'h1;
   localparam logic [3:0] OP_LDB   = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_CMP   = 4'h5;
   localparam logic [3:0] OP_JMP   = 4'h6;
   localparam logic [3:0] OP_JEQ   = 4'h7;
   localparam logic [3:0] OP_INCA  = 4'h8;
   localparam logic [3:0] OP_MOVBA = 4'h9;
`ifdef CPU_HALT_EN
   localparam logic [3:0] OP_HLT   = 4'hF;
`endif

   state_t            state_reg, state_next;
   logic [15:0]       ir_reg, ir_next;
   logic [PC_W-1:0]   pc_reg, pc_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] b_reg, b_next;
   logic              eq_reg, eq_next;

   logic [PC_W-1:0]   addr;
   logic [DATA_W-1:0] imm;

   assign addr = ir_reg[PC_W-1:0];
   assign imm  = ir_reg[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= FETCH;
         ir_reg    <= '0;
         pc_reg    <= PC_W'(RESET_PC);
         a_reg     <= '0;
         b_reg     <= '0;
         eq_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
         pc_reg    <= pc_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         eq_reg    <= eq_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ir_next    = ir_reg;
      pc_next    = pc_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      eq_next    = eq_reg;
      case (state_reg)
         FETCH: begin
            ir_next    = instr;
            state_next = DECODE;
         end
         DECODE: state_next = EXECUTE;
         EXECUTE: begin
            state_next = FETCH;
            pc_next    = pc_reg + PC_W'(1);
            case (ir_reg[15:12])
               OP_LDA:   a_next  = imm;
               OP_LDB:   b_next  = imm;
               OP_ADD:   a_next  = a_reg + b_reg;
               OP_SUB:   a_next  = a_reg - b_reg;
               OP_CMP:   eq_next = (a_reg == b_reg);
               OP_JMP:   pc_next = addr;
               // equal is still the pre-EXECUTE value here
               OP_JEQ:   if (eq_reg) pc_next = addr;
               OP_INCA:  a_next  = a_reg + DATA_W'(1);
               OP_MOVBA: b_next  = a_reg;
`ifdef CPU_HALT_EN
               OP_HLT: begin
                  state_next = HALT;
                  pc_next    = pc_reg;
               end
`endif
               default: ;
            endcase
         end
`ifdef CPU_HALT_EN
         HALT: state_next = HALT;
`endif
         default: state_next = FETCH;
      endcase
   end

   assign contador = pc_reg;
   assign opcode   = ir_reg[15:12];
   assign equal    = eq_reg;
   assign regA     = a_reg;
   assign regB     = b_reg;
`ifdef CPU_HALT_EN
   assign halted   = (state_reg == HALT);
`else
   assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_multiciclo.sv
// Bench for cpu_multiciclo: directed programs plus random programs checked against an
// instruction-level model (one model step per 3-cycle instruction).
module tb_cpu_multiciclo;

   logic        clk;
   logic        rst;
   logic [15:0] instr;
   logic [11:0] contador;
   logic [3:0]  opcode;
   logic        equal;
   logic [7:0]  regA;
   logic [7:0]  regB;
   logic        halted;

   logic [15:0] mem [0:4095];
   logic        glitch_en;
   logic [15:0] junk;

   int n_cmp;
   int n_err;
   int m_pc, m_a, m_b, m_eq, m_halt;

   // junk on instr outside FETCH must never reach the CPU
   assign instr = glitch_en ? junk : mem[contador];

   cpu_multiciclo #(.PC_W(12), .DATA_W(8), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .contador(contador), .opcode(opcode),
      .equal(equal), .regA(regA), .regB(regB), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pc"}, 16'(contador), 16'(m_pc));
      chk({tag, ".a"}, 16'(regA), 16'(m_a));
      chk({tag, ".b"}, 16'(regB), 16'(m_b));
      chk({tag, ".eq"}, 16'(equal), 16'(m_eq));
      chk({tag, ".halted"}, 16'(halted), 16'(m_halt));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pc"}, 16'(contador), 16'h0);
      chk({tag, ".op"}, 16'(opcode), 16'h0);
      chk({tag, ".eq"}, 16'(equal), 16'h0);
      chk({tag, ".a"}, 16'(regA), 16'h0);
      chk({tag, ".b"}, 16'(regB), 16'h0);
      chk({tag, ".halted"}, 16'(halted), 16'h0);
   endtask

   task automatic model_reset();
      m_pc = 0; m_a = 0; m_b = 0; m_eq = 0; m_halt = 0;
   endtask

   task automatic model_step();
      int op, opnd, nxt;
      op   = int'(mem[m_pc][15:12]);
      opnd = int'(mem[m_pc][11:0]);
      nxt  = (m_pc + 1) % 4096;
      if (m_halt != 0) return;
      case (op)
         1: m_a = opnd % 256;
         2: m_b = opnd % 256;
         3: m_a = (m_a + m_b) % 256;
         4: m_a = (m_a + 256 - m_b) % 256;
         5: m_eq = (m_a == m_b) ? 1 : 0;
         6: nxt = opnd;
         7: if (m_eq != 0) nxt = opnd;
         8: m_a = (m_a + 1) % 256;
         9: m_b = m_a;
`ifdef CPU_HALT_EN
         15: begin m_halt = 1; nxt = m_pc; end
`endif
         default: ;
      endcase
      m_pc = nxt;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;
      model_reset();
   endtask

   // one instruction: FETCH, DECODE, EXECUTE; contador must hold until EXECUTE
   task automatic exec_one(input string tag);
      int pc0;
      logic [3:0] op0;
      pc0 = m_pc;
      op0 = mem[m_pc][15:12];
      @(negedge clk);
      chk({tag, ".fetch_pc"}, 16'(contador), 16'(pc0));
      chk({tag, ".op"}, 16'(opcode), 16'(op0));
      glitch_en = 1'b1;
      junk = 16'($urandom);
      @(negedge clk);
      chk({tag, ".decode_pc"}, 16'(contador), 16'(pc0));
      junk = 16'($urandom);
      @(negedge clk);
      glitch_en = 1'b0;
      model_step();
      chk_model(tag);
      $display("instr pc=%03h ir=%04h -> pc=%03h a=%02h b=%02h eq=%0d", pc0, mem[pc0],
               contador, regA, regB, equal);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b0; glitch_en = 1'b0; junk = 16'h0;
      clear_mem();
      model_reset();

      // reset with a live instruction on the bus
      mem[0] = 16'h1055;
      do_reset();

      // load/add
      clear_mem();
      mem[0] = 16'h1005; mem[1] = 16'h2003; mem[2] = 16'h3000;
      do_reset();
      for (int i = 0; i < 3; i++) exec_one("ldadd");
      chk("ldadd.regA", 16'(regA), 16'h08);
      chk("ldadd.regB", 16'(regB), 16'h03);
      chk("ldadd.pc", 16'(contador), 16'h003);

      // wraparound arithmetic; equal untouched
      clear_mem();
      mem[0] = 16'h10FF; mem[1] = 16'h2001; mem[2] = 16'h3000;
      mem[3] = 16'h4000; mem[4] = 16'h8000;
      do_reset();
      for (int i = 0; i < 3; i++) exec_one("wrap");
      chk("wrap.add", 16'(regA), 16'h00);
      exec_one("wrap");
      chk("wrap.sub", 16'(regA), 16'hFF);
      exec_one("wrap");
      chk("wrap.inca", 16'(regA), 16'h00);
      chk("wrap.eq", 16'(equal), 16'h0);

      // compare, branch taken
      clear_mem();
      mem[0] = 16'h1007; mem[1] = 16'h2007; mem[2] = 16'h5000; mem[3] = 16'h7020;
      do_reset();
      for (int i = 0; i < 4; i++) exec_one("jeq_t");
      chk("jeq_t.eq", 16'(equal), 16'h1);
      chk("jeq_t.pc", 16'(contador), 16'h020);

      // compare, branch not taken
      mem[1] = 16'h2006;
      do_reset();
      for (int i = 0; i < 4; i++) exec_one("jeq_n");
      chk("jeq_n.eq", 16'(equal), 16'h0);
      chk("jeq_n.pc", 16'(contador), 16'h004);

      // jump to top of memory and wrap
      clear_mem();
      mem[0] = 16'h6FFF; mem[12'hFFF] = 16'h0000;
      do_reset();
      exec_one("jmp");
      chk("jmp.pc", 16'(contador), 16'hFFF);
      exec_one("jmp");
      chk("jmp.wrap", 16'(contador), 16'h000);

      // reset during DECODE of ADD
      clear_mem();
      mem[0] = 16'h1005; mem[1] = 16'h2003; mem[2] = 16'h3000;
      do_reset();
      exec_one("midrst");
      exec_one("midrst");
      @(negedge clk);
      chk("midrst.op", 16'(opcode), 16'h3);
      rst = 1'b0;
      @(negedge clk);
      chk_reset("midrst");
      rst = 1'b1;
      model_reset();
      exec_one("midrst_after");
      chk("midrst.refetch", 16'(regA), 16'h05);

      // opcode F
      clear_mem();
      mem[2] = 16'hF000; mem[3] = 16'h1033;
      do_reset();
      for (int i = 0; i < 3; i++) exec_one("halt");
`ifdef CPU_HALT_EN
      chk("halt.halted", 16'(halted), 16'h1);
      chk("halt.pc", 16'(contador), 16'h002);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt.hold_pc", 16'(contador), 16'h002);
         chk("halt.hold_flag", 16'(halted), 16'h1);
      end
      do_reset();
`else
      chk("halt.halted", 16'(halted), 16'h0);
      chk("halt.pc", 16'(contador), 16'h003);
`endif

      // random programs (opcode F kept out so the run is not frozen)
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h0;
         end
         do_reset();
         for (int i = 0; i < 200; i++) exec_one("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
